// File: rtl/gate_deadtime_guard.sv
// Last-line shoot-through / dead-time guard between the discharge controller and the gate-driver pins.
// Four independent leg FSMs plus a deion gate, all behind a sticky fault latch.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | leg off, ready to accept an up or down request
// UP     | up switch driven, on-time counted against MAX_UP_CYCLES
// DOWN   | down switch driven
// DEAD   | both switches off for DEAD_CYCLES clocks before any new gate-on
module gate_deadtime_guard #(
  parameter logic [15:0] DEAD_CYCLES   = 16'd10,
  parameter logic [15:0] MAX_UP_CYCLES = 16'd60000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] req_buck1,
  input  logic [1:0] req_buck2,
  input  logic [1:0] req_res1,
  input  logic [1:0] req_res2,
  input  logic       req_deion,
  input  logic       fault_clr,
  output logic [1:0] gate_buck1,
  output logic [1:0] gate_buck2,
  output logic [1:0] gate_res1,
  output logic [1:0] gate_res2,
  output logic       gate_deion,
  output logic [3:0] leg_ready,
  output logic       fault,
  output logic [8:0] fault_flags
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DEAD = 2'd3
  } leg_state_t;

  typedef struct packed {
    leg_state_t st;
    logic       ill;
    logic       ot;
  } leg_step_t;

  function automatic leg_step_t leg_step(leg_state_t st, logic dead_done, logic up_over,
                                         logic [1:0] eff);
    leg_step_t r;
    r.st  = st;
    r.ill = 1'b0;
    r.ot  = 1'b0;
    case (st)
      S_IDLE: begin
        case (eff)
          2'b10:   r.st = S_UP;
          2'b01:   r.st = S_DOWN;
          2'b11: begin
            r.st  = S_DEAD;
            r.ill = 1'b1;
          end
          default: r.st = S_IDLE;
        endcase
      end
      S_UP: begin
        if (eff == 2'b10) begin
          if (up_over) begin
            r.st = S_DEAD;
            r.ot = 1'b1;
          end
        end else begin
          r.st  = S_DEAD;
          r.ill = (eff == 2'b11);
        end
      end
      S_DOWN: begin
        if (eff != 2'b01) begin
          r.st  = S_DEAD;
          r.ill = (eff == 2'b11);
        end
      end
      default: begin
        if (dead_done) begin
          case (eff)
            2'b10:   r.st = S_UP;
            2'b01:   r.st = S_DOWN;
            default: r.st = S_IDLE;
          endcase
          r.ill = (eff == 2'b11);
        end
      end
    endcase
    return r;
  endfunction

  leg_state_t  st_q       [4];
  leg_state_t  st_nxt     [4];
  logic [15:0] dead_cnt_q [4];
  logic [15:0] up_cnt_q   [4];
  logic [1:0]  req_v      [4];
  logic [1:0]  eff0       [4];
  logic [1:0]  gate_q     [4];
  leg_step_t   pre        [4];
  leg_step_t   fin        [4];
  logic [3:0]  dead_done;
  logic [3:0]  up_over;
  logic [8:0]  det_flags;
  logic [8:0]  flags_nxt;
  logic        any_up_pre;
  logic        fault_any;
  logic        clr_ok;
  logic        deion_nxt;

  assign req_v[0] = req_buck1;
  assign req_v[1] = req_buck2;
  assign req_v[2] = req_res1;
  assign req_v[3] = req_res2;

  assign gate_buck1 = gate_q[0];
  assign gate_buck2 = gate_q[1];
  assign gate_res1  = gate_q[2];
  assign gate_res2  = gate_q[3];
  assign fault      = |fault_flags;

  // First pass finds new faults; any new fault then forces eff = 00 for every leg in the
  // same update, so all gates drop on the detecting edge rather than one clock later.
  always_comb begin
    eff0       = '{default: 2'b00};
    pre        = '{default: '0};
    fin        = '{default: '0};
    st_nxt     = '{default: S_DEAD};
    dead_done  = '0;
    up_over    = '0;
    det_flags  = '0;
    any_up_pre = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eff0[i]      = (enable && !fault) ? req_v[i] : 2'b00;
      dead_done[i] = ({1'b0, dead_cnt_q[i]} + 17'd1) >= {1'b0, DEAD_CYCLES};
      up_over[i]   = ({1'b0, up_cnt_q[i]} + 17'd1) >= {1'b0, MAX_UP_CYCLES};
      pre[i]       = leg_step(st_q[i], dead_done[i], up_over[i], eff0[i]);
      det_flags[i]     = pre[i].ill;
      det_flags[4 + i] = pre[i].ot;
      if (pre[i].st == S_UP) any_up_pre = 1'b1;
    end
    det_flags[8] = req_deion && any_up_pre;
    fault_any    = fault || (|det_flags);
    for (int i = 0; i < 4; i++) begin
      fin[i]    = leg_step(st_q[i], dead_done[i], up_over[i], 2'b00);
      st_nxt[i] = (fault_any && (pre[i].st == S_UP || pre[i].st == S_DOWN)) ? fin[i].st
                                                                           : pre[i].st;
    end
    clr_ok    = fault_clr && (req_v[0] == 2'b00) && (req_v[1] == 2'b00) &&
                (req_v[2] == 2'b00) && (req_v[3] == 2'b00) && !req_deion;
    flags_nxt = (clr_ok ? 9'd0 : fault_flags) | det_flags;
    deion_nxt = req_deion && enable && !fault_any && !any_up_pre;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]       <= S_DEAD;
        dead_cnt_q[i] <= 16'd0;
        up_cnt_q[i]   <= 16'd0;
        gate_q[i]     <= 2'b00;
      end
      leg_ready   <= 4'b0000;
      gate_deion  <= 1'b0;
      fault_flags <= 9'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        st_q[i] <= st_nxt[i];
        if (st_q[i] == S_DEAD && st_nxt[i] == S_DEAD)
          dead_cnt_q[i] <= (dead_cnt_q[i] == 16'hFFFF) ? dead_cnt_q[i] : dead_cnt_q[i] + 16'd1;
        else
          dead_cnt_q[i] <= 16'd0;
        if (st_q[i] == S_UP && st_nxt[i] == S_UP)
          up_cnt_q[i] <= (up_cnt_q[i] == 16'hFFFF) ? up_cnt_q[i] : up_cnt_q[i] + 16'd1;
        else
          up_cnt_q[i] <= 16'd0;
        case (st_nxt[i])
          S_UP:    gate_q[i] <= 2'b10;
          S_DOWN:  gate_q[i] <= 2'b01;
          default: gate_q[i] <= 2'b00;
        endcase
        leg_ready[i] <= (st_nxt[i] != S_DEAD);
      end
      gate_deion  <= deion_nxt;
      fault_flags <= flags_nxt;
    end
  end

endmodule

// File: tb/tb_gate_deadtime_guard.sv
// Directed bench for gate_deadtime_guard; MAX_UP_CYCLES shortened to 100 for the overtime case.
module tb_gate_deadtime_guard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] req_buck1, req_buck2, req_res1, req_res2;
  logic       req_deion;
  logic       fault_clr;
  logic [1:0] gate_buck1, gate_buck2, gate_res1, gate_res2;
  logic       gate_deion;
  logic [3:0] leg_ready;
  logic       fault;
  logic [8:0] fault_flags;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  gate_deadtime_guard #(
    .DEAD_CYCLES  (16'd10),
    .MAX_UP_CYCLES(16'd100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .req_buck1  (req_buck1),
    .req_buck2  (req_buck2),
    .req_res1   (req_res1),
    .req_res2   (req_res2),
    .req_deion  (req_deion),
    .fault_clr  (fault_clr),
    .gate_buck1 (gate_buck1),
    .gate_buck2 (gate_buck2),
    .gate_res1  (gate_res1),
    .gate_res2  (gate_res2),
    .gate_deion (gate_deion),
    .leg_ready  (leg_ready),
    .fault      (fault),
    .fault_flags(fault_flags)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_reqs();
    req_buck1 = 2'b00;
    req_buck2 = 2'b00;
    req_res1  = 2'b00;
    req_res2  = 2'b00;
    req_deion = 1'b0;
  endtask

  function automatic logic [8:0] all_gates();
    return {gate_buck1, gate_buck2, gate_res1, gate_res2, gate_deion};
  endfunction

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    fault_clr = 1'b0;
    idle_reqs();
    req_buck1 = 2'b10;
    repeat (3) @(negedge clk);

    // 1: reset release with buck1 up held
    rst_n = 1'b1;
    chk("rst_gates", all_gates(), 9'd0);
    chk("rst_leg_ready", leg_ready, 4'h0);
    chk("rst_flags", fault_flags, 9'd0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("rst_dead_buck1", gate_buck1, 2'b00);
    end
    @(negedge clk);
    chk("rst_release_up", gate_buck1, 2'b10);
    chk("rst_release_ready", leg_ready, 4'hF);

    // 2: direct up -> down switch-over
    @(negedge clk);
    chk("up_hold", gate_buck1, 2'b10);
    req_buck1 = 2'b01;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("switch_dead_gate", gate_buck1, 2'b00);
      chk("switch_dead_ready", leg_ready[0], 1'b0);
    end
    @(negedge clk);
    chk("switch_down", gate_buck1, 2'b01);
    req_buck1 = 2'b00;
    repeat (12) @(negedge clk);

    // 3: illegal request, fault latch and clear rules
    req_buck1 = 2'b10;
    @(negedge clk);
    chk("pre_fault_up", gate_buck1, 2'b10);
    req_res2 = 2'b11;
    @(negedge clk);
    chk("ill_flags", fault_flags, 9'h008);
    chk("ill_fault", fault, 1'b1);
    chk("ill_gates_off", all_gates(), 9'd0);
    req_res2  = 2'b00;
    fault_clr = 1'b1;
    @(negedge clk);
    chk("clr_blocked", fault_flags, 9'h008);
    req_buck1 = 2'b00;
    @(negedge clk);
    chk("clr_ok_flags", fault_flags, 9'd0);
    chk("clr_ok_fault", fault, 1'b0);
    fault_clr = 1'b0;
    req_buck1 = 2'b10;
    repeat (10) @(negedge clk);
    chk("resume_up", gate_buck1, 2'b10);
    chk("resume_flags", fault_flags, 9'd0);
    req_buck1 = 2'b00;
    repeat (12) @(negedge clk);

    // 4: up-overtime on buck2
    req_buck2 = 2'b10;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      chk("ot_on", gate_buck2, 2'b10);
    end
    @(negedge clk);
    chk("ot_off", gate_buck2, 2'b00);
    chk("ot_flags", fault_flags, 9'h020);
    chk("ot_fault", fault, 1'b1);
    req_buck2 = 2'b00;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("ot_clr", fault_flags, 9'd0);
    repeat (12) @(negedge clk);

    // 5: deion conflict, then deion with all legs down
    req_deion = 1'b1;
    req_res1  = 2'b10;
    @(negedge clk);
    chk("deion_conf_gate", gate_deion, 1'b0);
    chk("deion_conf_flags", fault_flags, 9'h100);
    chk("deion_conf_res1", gate_res1, 2'b00);
    idle_reqs();
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("deion_clr", fault_flags, 9'd0);
    repeat (12) @(negedge clk);
    req_buck1 = 2'b01;
    req_buck2 = 2'b01;
    req_res1  = 2'b01;
    req_res2  = 2'b01;
    req_deion = 1'b1;
    @(negedge clk);
    chk("deion_ok_gates", all_gates(), 9'b01_01_01_01_1);
    chk("deion_ok_flags", fault_flags, 9'd0);
    idle_reqs();
    @(negedge clk);
    chk("deion_release", gate_deion, 1'b0);
    repeat (12) @(negedge clk);

    // 6: enable drop while up
    req_buck1 = 2'b10;
    @(negedge clk);
    chk("en_up", gate_buck1, 2'b10);
    enable = 1'b0;
    @(negedge clk);
    chk("en_drop_gate", gate_buck1, 2'b00);
    chk("en_drop_ready", leg_ready[0], 1'b0);
    repeat (9) @(negedge clk);
    chk("en_dead_end_ready", leg_ready[0], 1'b0);
    @(negedge clk);
    chk("en_idle_ready", leg_ready[0], 1'b1);
    chk("en_idle_gate", gate_buck1, 2'b00);
    chk("en_no_flag", fault_flags, 9'd0);

    // reset mid-operation
    enable = 1'b1;
    @(negedge clk);
    chk("mid_up", gate_buck1, 2'b10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_gates", all_gates(), 9'd0);
    chk("mid_rst_ready", leg_ready, 4'h0);
    rst_n = 1'b1;
    idle_reqs();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
